// File: rtl/inst_stream_encoder_pkg.sv
// rv_enc_pkg: opcodes, FSM state encoding and field tuple shared by the encoder slice
package rv_enc_pkg;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} enc_state_t;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [11:0] imm;
    logic [19:0] imm20;
  } inst_fields_t;
endpackage

// File: rtl/inst_stream_encoder_if.sv
// inst_stream_encoder_if: command, tuple stream and memory write port of the encoder
interface inst_stream_encoder_if #(parameter int ADDR_W = 32, parameter int CNT_W = 16);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_cnt;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_func3;
  logic [6:0]        in_func7;
  logic [11:0]       in_imm;
  logic [19:0]       in_imm20;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  err_cnt;
  modport slave (
    input  start, base_addr, word_cnt, in_valid, in_opcode, in_rd, in_rs1, in_rs2,
           in_func3, in_func7, in_imm, in_imm20, mem_ready,
    output in_ready, mem_valid, mem_addr, mem_wdata, busy, done, err_cnt
  );
  modport master (
    output start, base_addr, word_cnt, in_valid, in_opcode, in_rd, in_rs1, in_rs2,
           in_func3, in_func7, in_imm, in_imm20, mem_ready,
    input  in_ready, mem_valid, mem_addr, mem_wdata, busy, done, err_cnt
  );
endinterface

// File: rtl/inst_stream_encoder_packer.sv
// inst_field_packer: packs one decoded RV32 field tuple into an instruction word
module inst_field_packer
  import rv_enc_pkg::*;
(
  input  inst_fields_t f,
  output logic [31:0]  word,
  output logic         illegal
);
  // format selection by opcode; unknown opcodes and bad R-type funct7 are flagged
  always_comb begin
    word = '0;
    illegal = 1'b0;
    case (f.opcode)
      OP_R: begin
        word = {f.func7, f.rs2, f.rs1, f.func3, f.rd, f.opcode};
        illegal = !(f.func7 == 7'h00 || f.func7 == 7'h20 || f.func7 == 7'h01);
      end
      OP_I:             word = {f.imm, f.rs1, f.func3, f.rd, f.opcode};
      OP_S:             word = {f.imm[11:5], f.rs2, f.rs1, f.func3, f.imm[4:0], f.opcode};
      OP_B:             word = {f.imm[11], f.imm[9:4], f.rs2, f.rs1, f.func3, f.imm[3:0], f.imm[10], f.opcode};
      OP_LUI, OP_AUIPC: word = {f.imm20, f.rd, f.opcode};
      OP_JAL:           word = {f.imm20[19], f.imm20[9:0], f.imm20[10], f.imm20[18:11], f.rd, f.opcode};
      default:          illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/inst_stream_encoder.sv
// inst_stream_encoder: consumes field tuples and writes encoded words sequentially to memory
module inst_stream_encoder
  import rv_enc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  inst_stream_encoder_if.slave bus
);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_LOAD  = LOAD;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;
  logic [1:0]        state;
  logic [CNT_W-1:0]  rem;
  logic [ADDR_W-1:0] addr_ptr;
  inst_fields_t      f;
  logic [31:0]       word;
  logic              illegal;
  logic              acc;
  logic              wr;
  assign f = {bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_func3,
              bus.in_func7, bus.in_imm, bus.in_imm20};
  inst_field_packer u_packer (.f(f), .word(word), .illegal(illegal));
  assign bus.in_ready = state == S_LOAD && (!bus.mem_valid || bus.mem_ready);
  assign acc          = bus.in_valid && bus.in_ready;
  assign wr           = bus.mem_valid && bus.mem_ready;
  assign bus.mem_addr = addr_ptr;
  assign bus.busy     = state == S_LOAD || state == S_DRAIN;
  assign bus.done     = state == S_DONE;
  // FSM, counters and the single output register; the pending word always sits at addr_ptr
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rem           <= '0;
      addr_ptr      <= '0;
      bus.mem_valid <= 1'b0;
      bus.mem_wdata <= '0;
      bus.err_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          addr_ptr    <= {bus.base_addr[ADDR_W-1:2], 2'b00};
          rem         <= bus.word_cnt;
          bus.err_cnt <= '0;
          state       <= bus.word_cnt == '0 ? S_DONE : S_LOAD;
        end
        S_LOAD: if (acc) begin
          rem   <= rem - CNT_W'(1);
          state <= rem == CNT_W'(1) ? S_DRAIN : S_LOAD;
        end
        S_DRAIN: state <= (!bus.mem_valid || bus.mem_ready) ? S_DONE : S_DRAIN;
        default: state <= S_IDLE;
      endcase
      if (acc && !illegal) begin
        bus.mem_valid <= 1'b1;
        bus.mem_wdata <= word;
      end else if (wr) bus.mem_valid <= 1'b0;
      if (wr) addr_ptr <= addr_ptr + ADDR_W'(4);
      if (acc && illegal && !(&bus.err_cnt)) bus.err_cnt <= bus.err_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_inst_stream_encoder.sv
// tb_inst_stream_encoder: directed vectors with hand-encoded expected instruction words
module tb_inst_stream_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0, fails = 0, cyc = 0, dcnt = 0, dcyc = 0;
  logic [31:0] wa[$], wd[$];
  int wcyc[$];
  logic [31:0] ea[4], ed[4];
  logic [31:0] w;
  int d0;

  inst_stream_encoder_if #(.ADDR_W(32), .CNT_W(16)) bus();
  inst_stream_encoder #(.ADDR_W(32), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && bus.mem_valid && bus.mem_ready) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
      wcyc.push_back(cyc);
    end
    if (bus.done) begin
      dcnt++;
      dcyc = cyc;
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    wa.delete();
    wd.delete();
    wcyc.delete();
  endtask

  task automatic go(input logic [31:0] base, input logic [15:0] n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.word_cnt = n;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic put(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [11:0] imm, input logic [19:0] imm20);
    bus.in_opcode = op;
    bus.in_rd = rd;
    bus.in_rs1 = rs1;
    bus.in_rs2 = rs2;
    bus.in_func3 = f3;
    bus.in_func7 = f7;
    bus.in_imm = imm;
    bus.in_imm20 = imm20;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [11:0] imm, input logic [19:0] imm20);
    int n;
    put(op, rd, rs1, rs2, f3, f7, imm, imm20);
    bus.in_valid = 1'b1;
    for (n = 0; n < 50 && !bus.in_ready; n++) @(negedge clk);
    chk("send_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int base_cnt);
    int n;
    for (n = 0; n < 100 && !bus.done; n++) @(negedge clk);
    chk("done_seen", {31'b0, bus.done}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("done_pulses", dcnt - base_cnt, 32'd1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.word_cnt = '0;
    bus.in_valid = 1'b0;
    bus.mem_ready = 1'b1;
    put(7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 12'h0, 20'h0);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_mem_valid", {31'b0, bus.mem_valid}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_err_cnt", {16'b0, bus.err_cnt}, 32'd0);
    rst_n = 1'b1;

    d0 = dcnt;
    clr();
    go(32'h103, 16'd1);
    chk("busy_load", {31'b0, bus.busy}, 32'd1);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 12'h0, 20'h0);
    wait_done(d0);
    chk("add_writes", wa.size(), 32'd1);
    chk("add_addr", wa[0], 32'h100);
    chk("add_data", wd[0], 32'h002081B3);
    if (wcyc.size() == 1) chk("add_done_lat", dcyc - wcyc[0], 32'd1);

    ea = '{32'h100, 32'h104, 32'h108, 32'h10C};
    ed = '{32'h00500093, 32'h0020A423, 32'h00208463, 32'h123452B7};
    d0 = dcnt;
    clr();
    go(32'h100, 16'd4);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 12'd5, 20'h0);
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 12'd8, 20'h0);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 12'h004, 20'h0);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 12'h0, 20'h12345);
    wait_done(d0);
    chk("seq_writes", wa.size(), 32'd4);
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      chk($sformatf("seq_addr%0d", i), wa[i], ea[i]);
      chk($sformatf("seq_data%0d", i), wd[i], ed[i]);
    end

    d0 = dcnt;
    clr();
    go(32'h300, 16'd1);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 12'h0, 20'h00008);
    wait_done(d0);
    chk("jal_writes", wa.size(), 32'd1);
    chk("jal_data", wd[0], 32'h010000EF);
    w = wd[0];
    chk("jal_dec_rd", {27'b0, w[11:7]}, 32'd1);
    chk("jal_dec_op", {25'b0, w[6:0]}, 32'h6F);

    d0 = dcnt;
    clr();
    go(32'h200, 16'd3);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 12'd5, 20'h0);
    send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 12'h0, 20'h0);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 12'h0, 20'h0);
    wait_done(d0);
    chk("ill_writes", wa.size(), 32'd2);
    chk("ill_addr0", wa[0], 32'h200);
    chk("ill_addr1", wa[1], 32'h204);
    chk("ill_data1", wd[1], 32'h002081B3);
    chk("ill_err_cnt", {16'b0, bus.err_cnt}, 32'd1);

    d0 = dcnt;
    clr();
    go(32'h600, 16'd1);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h7F, 12'h0, 20'h0);
    wait_done(d0);
    chk("f7_writes", wa.size(), 32'd0);
    chk("f7_err_cnt", {16'b0, bus.err_cnt}, 32'd1);

    d0 = dcnt;
    clr();
    go(32'h400, 16'd3);
    bus.mem_ready = 1'b0;
    put(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 12'd5, 20'h0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    put(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 12'h0, 20'h0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("bp_mem_valid", {31'b0, bus.mem_valid}, 32'd1);
      chk("bp_mem_addr", bus.mem_addr, 32'h400);
      chk("bp_mem_wdata", bus.mem_wdata, 32'h00500093);
      @(negedge clk);
    end
    chk("bp_no_write", wa.size(), 32'd0);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    put(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 12'h0, 20'h12345);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done(d0);
    chk("bp_writes", wa.size(), 32'd3);
    chk("bp_addr2", wa[2], 32'h408);
    chk("bp_data0", wd[0], 32'h00500093);
    chk("bp_data1", wd[1], 32'h002081B3);
    chk("bp_data2", wd[2], 32'h123452B7);
    if (wcyc.size() == 3) chk("bp_no_bubble", wcyc[2] - wcyc[0], 32'd2);

    d0 = dcnt;
    clr();
    go(32'h700, 16'd0);
    chk("zero_done", {31'b0, bus.done}, 32'd1);
    @(negedge clk);
    chk("zero_done_low", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    chk("zero_pulses", dcnt - d0, 32'd1);
    chk("zero_writes", wa.size(), 32'd0);

    clr();
    go(32'h500, 16'd3);
    bus.mem_ready = 1'b0;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 12'd5, 20'h0);
    chk("mid_pending", {31'b0, bus.mem_valid}, 32'd1);
    d0 = dcnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("mid_mem_valid", {31'b0, bus.mem_valid}, 32'd0);
    chk("mid_mem_addr", bus.mem_addr, 32'd0);
    chk("mid_mem_wdata", bus.mem_wdata, 32'd0);
    chk("mid_busy", {31'b0, bus.busy}, 32'd0);
    chk("mid_err_cnt", {16'b0, bus.err_cnt}, 32'd0);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_no_done", dcnt - d0, 32'd0);
    chk("mid_no_write", wa.size(), 32'd0);
    chk("mid_idle", {31'b0, bus.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inst_stream_encoder.md
Name: inst_stream_encoder

Overview:
- Inverse of the instruction decoder: takes decoded RV32 field tuples and packs them into 32-bit instruction words, then writes them sequentially into instruction memory.
- Used by the test/boot infrastructure to load programs from a field-level stream, for example from a host or a self-test generator.
- A start command gives a base address and a word count. The block accepts that many tuples on a valid/ready input, encodes each one, and issues one memory write per legal word over a valid/ready write port.
- Round-trip with the decoder is exact for every supported format.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- CNT_W, 16, width of the word-count and error counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; honoured only in IDLE
- base_addr  in  ADDR_W  first write address; bits [1:0] ignored (forced 0)
- word_cnt  in  CNT_W  number of input tuples to consume; 0 means finish immediately
- in_valid  in  1  tuple valid
- in_ready  out  1  tuple accepted when in_valid && in_ready
- in_opcode  in  7  opcode
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_func3  in  3  funct3
- in_func7  in  7  funct7
- in_imm  in  12  I/S immediate [11:0]; for B-type, holds offset[12:1]
- in_imm20  in  20  U-type immediate [31:12]; for J-type, holds offset[20:1]
- mem_valid  out  1  write request
- mem_ready  in  1  memory accepts the write when mem_valid && mem_ready
- mem_addr  out  ADDR_W  write byte address
- mem_wdata  out  32  encoded instruction
- busy  out  1  high in LOAD and DRAIN
- done  out  1  one-cycle pulse when a load completes
- err_cnt  out  CNT_W  number of illegal tuples in the current or most recent load

Behaviour:
- Reset: all of the following are 0 and the FSM is in IDLE:
  - in_ready, mem_valid, mem_addr, mem_wdata
  - busy, done, err_cnt
  - internal remaining count and address pointer
- FSM states:
  - IDLE: in_ready=0. On start: latch addr_ptr = {base_addr[ADDR_W-1:2], 2'b00} and remaining = word_cnt, clear err_cnt. If word_cnt==0, go to DONE; otherwise go to LOAD.
  - LOAD: in_ready = !out_reg_full || mem_ready (single output register, pass-through when draining). Each accept decrements remaining. When an accept makes remaining reach 0, go to DRAIN.
  - DRAIN: in_ready=0. Wait until the output register is empty, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE. err_cnt holds until the next start.
- start outside IDLE is ignored.
- Latency: accepted tuple → mem_valid on the next cycle, i.e. one register stage.
- mem_addr and mem_wdata are stable while mem_valid && !mem_ready.
- addr_ptr advances by 4 only on a memory handshake and wraps modulo 2^ADDR_W.
- Encoding by opcode:
  - R (0110011): {func7, rs2, rs1, func3, rd, op}
  - I (0010011): {imm[11:0], rs1, func3, rd, op}
  - S (0100011): {imm[11:5], rs2, rs1, func3, imm[4:0], op}
  - B (1100011): inst[31]=imm[11], inst[7]=imm[10], inst[30:25]=imm[9:4], inst[11:8]=imm[3:0]; rs2, rs1, func3 in their standard positions
  - U (0110111, 0010111): {imm20, rd, op}
  - J (1101111): inst[31]=imm20[19], inst[30:21]=imm20[9:0], inst[20]=imm20[10], inst[19:12]=imm20[18:11]; rd, op in their standard positions
- Fields not used by the format are ignored.
- Illegal tuples:
  - Definition: any other opcode, or R-type with func7 not in {0000000, 0100000, 0000001}.
  - The tuple is still consumed and counts toward remaining.
  - No write is issued and addr_ptr does not advance.
  - err_cnt increments, saturating at all-ones.
- Simultaneous accept and write in the same cycle: the output register reloads with no bubble.
- Reset mid-load: the load is aborted, any pending write is dropped, and the block returns to IDLE with no done pulse.

Decomposition:
- Shared package rv_enc_pkg contains:
  - opcode localparams (OP_R, OP_I, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL)
  - typedef enum enc_state_t {IDLE, LOAD, DRAIN, DONE}
  - typedef struct packed inst_fields_t holding all input fields
- Combinational sub-module inst_field_packer: takes inst_fields_t and outputs the 32-bit word plus an illegal flag. Keep it separate so it can be checked standalone against the decoder.
- The top level holds the FSM, counters, and output register.

Test Plan:
- start, base 0x100, cnt 1, ADD (op 0110011, rd3, rs1 1, rs2 2, f3 0, f7 0) → one write, addr 0x100, data 0x002081B3, done one cycle later.
- cnt 4, tuples:
  - ADDI x1,x0,5
  - SW x2,8(x1)
  - BEQ x1,x2 with imm 0x004
  - LUI x5 with imm20 0x12345

  Expect data 0x00500093, 0x0020A423, 0x00208463, 0x123452B7 at addresses 0x100, 0x104, 0x108, 0x10C.
- JAL x1 with imm20 0x00008 → data 0x010000EF. Feed the result to the decoder and confirm rd=1 and opcode match.
- cnt 3, middle tuple has opcode 0x7F → two writes at 0x200 and 0x204, err_cnt=1, done pulses.
- Hold mem_ready=0 for 5 cycles with in_valid=1 → at most 1 word is pending, in_ready=0, mem_addr and mem_wdata stable. Release and all words arrive in order with no loss.
- word_cnt=0 → done 2 cycles after start with no writes. Separately, rst_n low during LOAD → all outputs 0 the next cycle and no done pulse.
